// File: rtl/cross_bar_pkg.sv
// Shared configuration and FSM state type for the cross-bar arbiter slice.
package cross_bar_pkg;

  localparam int unsigned MASTER_N       = 4;
  localparam int unsigned WEIGHT_W       = 2;
  localparam int unsigned TIMEOUT_CYCLES = 256;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cross_bar_rr_pick.sv
// Masked round-robin pick: first requester at or after ptr, wrapping MASTER_N-1 -> 0.
module cross_bar_rr_pick #(
  parameter int unsigned MASTER_N = 4
) (
  input  logic [MASTER_N-1:0]         req,
  input  logic [$clog2(MASTER_N)-1:0] ptr,
  output logic [MASTER_N-1:0]         pick,
  output logic [$clog2(MASTER_N)-1:0] pick_idx,
  output logic                        pick_valid
);

  localparam int unsigned IDX_W = $clog2(MASTER_N);

  always_comb begin
    int unsigned j;
    pick       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    j          = 0;
    for (int unsigned off = 0; off < MASTER_N; off++) begin
      j = 32'(ptr) + off;
      if (j >= MASTER_N) j = j - MASTER_N;
      if (!pick_valid && req[j]) begin
        pick_valid = 1'b1;
        pick[j]    = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/cross_bar_wrr_arbiter.sv
// Weighted round-robin arbiter: a master with weight w holds w+1 consecutive grants.
// Optional grant watchdog enabled by defining CROSS_BAR_ARB_TIMEOUT_EN.
module cross_bar_wrr_arbiter #(
  parameter int unsigned MASTER_N       = cross_bar_pkg::MASTER_N,
  parameter int unsigned WEIGHT_W       = cross_bar_pkg::WEIGHT_W,
  parameter int unsigned TIMEOUT_CYCLES = cross_bar_pkg::TIMEOUT_CYCLES
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic [MASTER_N-1:0]                req,
  input  logic [MASTER_N-1:0][WEIGHT_W-1:0]  weight,
  input  logic                               done,
  output logic [MASTER_N-1:0]                grant,
  output logic [$clog2(MASTER_N)-1:0]        grant_idx,
  output logic                               timeout
);

  import cross_bar_pkg::*;

  localparam int unsigned IDX_W = $clog2(MASTER_N);

  arb_state_e                        state_q, state_d;
  logic [MASTER_N-1:0]               grant_q, grant_d;
  logic [IDX_W-1:0]                  owner_q, owner_d;
  logic [IDX_W-1:0]                  ptr_q, ptr_d;
  logic [MASTER_N-1:0][WEIGHT_W-1:0] credit_q, credit_d;
  // carry_q: ptr parked on the last owner because it still had credit left
  logic                              carry_q, carry_d;

  logic [MASTER_N-1:0] pick;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  logic [IDX_W-1:0]    next_owner;
  logic                expire;

  cross_bar_rr_pick #(
    .MASTER_N(MASTER_N)
  ) u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .pick      (pick),
    .pick_idx  (pick_idx),
    .pick_valid(pick_valid)
  );

  assign next_owner = (owner_q == IDX_W'(MASTER_N - 1)) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    carry_d  = carry_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          grant_d = pick;
          owner_d = pick_idx;
          carry_d = 1'b0;
          // Parked owner re-won: keep its remaining credit; otherwise drop it and load fresh.
          if (!(carry_q && (pick_idx == ptr_q))) begin
            if (carry_q) credit_d[ptr_q] = '0;
            credit_d[pick_idx] = weight[pick_idx];
          end
        end
      end
      ST_GRANT: begin
        if (done || expire) begin
          state_d = ST_IDLE;
          grant_d = '0;
          if (done && (credit_q[owner_q] != '0)) begin
            credit_d[owner_q] = credit_q[owner_q] - WEIGHT_W'(1);
            ptr_d             = owner_q;
            carry_d           = 1'b1;
          end else begin
            credit_d[owner_q] = '0;
            ptr_d             = next_owner;
            carry_d           = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      carry_q  <= carry_d;
    end
  end

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  // wd_q counts completed GRANT cycles; the TIMEOUT_CYCLES-th one releases.
  assign expire = (state_q == ST_GRANT) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire && !done;
      if ((state_q == ST_GRANT) && !done && !expire) wd_q <= wd_q + WD_W'(1);
      else                                           wd_q <= '0;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign grant     = grant_q;
  assign grant_idx = owner_q;

endmodule

// File: tb/tb_cross_bar_wrr_arbiter.sv
// Self-checking bench: burst-based reference model compared every cycle, plus directed literal checks.
module tb_cross_bar_wrr_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic               clk     = 1'b0;
  logic               aresetn = 1'b0;
  logic               done    = 1'b0;
  logic [N-1:0]       req     = '0;
  logic [N-1:0][1:0]  weight  = '0;
  logic [N-1:0]       grant;
  logic [1:0]         grant_idx;
  logic               timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int gseq[$];
  int exp_q[$];

  // Model: a burst is w+1 grants to one master; b_left = grants still owed after the current one.
  bit m_busy;
  int m_owner, m_ptr, b_owner, b_left, m_gcyc;
  bit m_to;

  cross_bar_wrr_arbiter #(
    .MASTER_N      (N),
    .WEIGHT_W      (2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .req      (req),
    .weight   (weight),
    .done     (done),
    .grant    (grant),
    .grant_idx(grant_idx),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit reached: got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
  endtask

  function automatic void model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; b_owner = -1; b_left = 0; m_gcyc = 0; m_to = 0;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input bit d, input int w[N]);
    int cand;
    bit found;
    m_to  = 0;
    found = 0;
    cand  = 0;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!found && r[(m_ptr + k) % N]) begin
          found = 1;
          cand  = (m_ptr + k) % N;
        end
      end
      if (found) begin
        if (cand == b_owner && b_left > 0) b_left--;
        else begin
          b_owner = cand;
          b_left  = w[cand];
        end
        m_owner = cand;
        m_busy  = 1;
        m_gcyc  = 0;
      end
    end else if (d) begin
      m_busy = 0;
      if (b_left > 0) m_ptr = m_owner;
      else begin
        m_ptr   = (m_owner + 1) % N;
        b_owner = -1;
      end
    end else begin
      m_gcyc++;
      if (TO_EN && m_gcyc == TO) begin
        m_busy  = 0;
        m_to    = 1;
        m_ptr   = (m_owner + 1) % N;
        b_owner = -1;
        b_left  = 0;
      end
    end
  endfunction

  logic [N-1:0] prev_grant = '0;

  always @(posedge clk) begin : compare
    logic [N-1:0] r;
    bit           d;
    int           w[N];
    r = req;
    d = done;
    for (int i = 0; i < N; i++) w[i] = int'(weight[i]);
    #1;
    if (!aresetn) model_reset();
    else          model_step(r, d, w);
    chk("grant", 32'(grant), m_busy ? (32'd1 << m_owner) : 32'd0);
    if (m_busy) chk("grant_idx", 32'(grant_idx), m_owner);
    chk("timeout", 32'(timeout), 32'(m_to));
    if (grant != '0 && prev_grant == '0) gseq.push_back(int'(grant_idx));
    prev_grant = grant;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    done    = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_idx", 32'(grant_idx), 0);
    chk("rst_timeout", 32'(timeout), 0);
    aresetn = 1'b1;
    gseq.delete();
  endtask

  task automatic wait_grant(output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (grant != '0) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_grant at %0t: got no grant expected grant within 30 cycles", $time);
    end
  endtask

  task automatic serve(input int hold);
    bit ok;
    wait_grant(ok);
    if (!ok) return;
    repeat (hold - 1) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic check_seq(input string nm, input int e[$]);
    chk({nm, "_len"}, gseq.size(), e.size());
    for (int k = 0; k < e.size(); k++)
      if (k < gseq.size()) chk($sformatf("%s[%0d]", nm, k), gseq[k], e[k]);
  endtask

  initial begin
    bit ok;
    int cnt;

    // Plain round-robin, all weights zero
    do_reset();
    req = 4'b1111;
    repeat (5) serve(2);
    req = '0;
    exp_q = '{0, 1, 2, 3, 0};
    check_seq("rr_order", exp_q);

    // Weighted: master 0 weight 2 -> 3 grants, then master 1
    do_reset();
    weight = '{2'd0, 2'd0, 2'd0, 2'd2};
    req = 4'b0011;
    repeat (8) serve(3);
    req = '0;
    exp_q = '{0, 0, 0, 1, 0, 0, 0, 1};
    check_seq("weight_seq", exp_q);

    // Owner drops mid-burst; credit discarded and reloaded later
    do_reset();
    req = 4'b0101;
    serve(1);
    req = 4'b0100;
    serve(1);
    req = 4'b0101;
    repeat (4) serve(1);
    req = '0;
    exp_q = '{0, 2, 0, 0, 0, 2};
    check_seq("drop_seq", exp_q);

    // done coincident with new req[3]
    do_reset();
    weight = '0;
    req = 4'b0100;
    wait_grant(ok);
    tick();
    done = 1'b1;
    req  = 4'b1100;
    tick();
    done = 1'b0;
    chk("simul_idle", 32'(grant), 0);
    tick();
    chk("simul_grant", 32'(grant), 32'b1000);
    chk("simul_idx", 32'(grant_idx), 3);
    req  = '0;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();

    // Owner 1 never signals done
    do_reset();
    req = 4'b0110;
    wait_grant(ok);
    chk("to_owner", 32'(grant_idx), 1);
    cnt = 1;
    while (grant == 4'b0010 && cnt < 20) begin
      tick();
      if (grant == 4'b0010) cnt++;
    end
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
    chk("to_hold_cycles", cnt, TO);
    chk("to_pulse", 32'(timeout), 1);
    tick();
    chk("to_pulse_end", 32'(timeout), 0);
    chk("to_next_grant", 32'(grant), 32'b0100);
`else
    chk("hold_forever", cnt, 20);
    chk("no_timeout", 32'(timeout), 0);
`endif
    req  = '0;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();

    // Reset during GRANT of master 3
    do_reset();
    req = 4'b1000;
    wait_grant(ok);
    chk("mid_rst_owner", 32'(grant), 32'b1000);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_drop", 32'(grant), 0);
    tick();
    tick();
    req     = 4'b1001;
    aresetn = 1'b1;
    tick();
    chk("mid_rst_restart", 32'(grant), 32'b0001);
    req  = '0;
    done = 1'b1;
    tick();
    done = 1'b0;

    // Randomized traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      req  = N'($urandom_range(0, 15));
      done = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0)
        for (int i = 0; i < N; i++) weight[i] = 2'($urandom_range(0, 3));
      if (cyc == 1500) begin
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
      end
      tick();
    end
    req  = '0;
    done = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
